// File: rtl/pipeline_8bit_subtractor.sv
// ============================================================================
// Module   : pipeline_8bit_subtractor
// Brief    : Two-stage valid/ready pipelined subtractor (a - b - bin), split
//            into low/high halves with the half borrow registered between
//            stages. Optional signed-overflow output under SUB_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_8bit_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             enable,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_LO = WIDTH / 2;
  localparam int c_HI = WIDTH - c_LO;

  logic            r_s1_valid;
  logic [c_LO-1:0] r_s1_lo;
  logic            r_s1_borrow;
  logic [c_HI-1:0] r_s1_a_hi;
  logic [c_HI-1:0] r_s1_b_hi;

  logic            w_s2_advance;
  logic            w_in_xfer;
  logic            w_s1_move;
  logic [c_LO:0]   w_lo_sub;
  logic [c_HI:0]   w_hi_sub;

  assign w_s2_advance = ~out_valid | out_ready;
  assign in_ready     = ~r_s1_valid | w_s2_advance;
  assign w_in_xfer    = in_valid & in_ready;
  assign w_s1_move    = r_s1_valid & w_s2_advance;

  // The MSB of each extended difference is the borrow out of that half.
  assign w_lo_sub = {1'b0, a[c_LO-1:0]} - {1'b0, b[c_LO-1:0]} - {{c_LO{1'b0}}, bin};
  assign w_hi_sub = {1'b0, r_s1_a_hi} - {1'b0, r_s1_b_hi} - {{c_HI{1'b0}}, r_s1_borrow};

  always_ff @(posedge enable or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo     <= '0;
      r_s1_borrow <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid  <= 1'b1;
      r_s1_lo     <= w_lo_sub[c_LO-1:0];
      r_s1_borrow <= w_lo_sub[c_LO];
      r_s1_a_hi   <= a[WIDTH-1:c_LO];
      r_s1_b_hi   <= b[WIDTH-1:c_LO];
    end else if (w_s1_move) begin
      r_s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge enable or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
    end else if (w_s1_move) begin
      out_valid <= 1'b1;
      diff      <= {w_hi_sub[c_HI-1:0], r_s1_lo};
      bout      <= w_hi_sub[c_HI];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic r_s1_a_msb;
  logic r_s1_b_msb;

  always_ff @(posedge enable or negedge rst) begin
    if (!rst) begin
      r_s1_a_msb <= 1'b0;
      r_s1_b_msb <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_a_msb <= a[WIDTH-1];
      r_s1_b_msb <= b[WIDTH-1];
    end
  end

  // Overflow when operand signs differ and the result sign differs from a.
  always_ff @(posedge enable or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (w_s1_move) begin
      ovf <= (r_s1_a_msb != r_s1_b_msb) && (w_hi_sub[c_HI-1] != r_s1_a_msb);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_8bit_subtractor.sv
// Directed self-checking bench for pipeline_8bit_subtractor.
`default_nettype none

module tb_pipeline_8bit_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] diff;
  logic       bout;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int checks = 0;
  int failures = 0;

  pipeline_8bit_subtractor #(.WIDTH(8)) dut (
    .enable    (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated operand set: accept, then result two edges later.
  task automatic send_one(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vbin, input logic [7:0] ed, input logic eb,
                          input logic eo);
    a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = 8'hAA; b = 8'h55; bin = 1'b1;
    check({tag, "_v1"}, {31'd0, out_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SUB_OVERFLOW_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unused");
`endif
    step();
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [7:0] bp_a   [4] = '{8'h09, 8'h19, 8'h29, 8'h39};
  logic [7:0] bp_b   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] bp_exp [4] = '{8'h08, 8'h17, 8'h26, 8'h35};

  initial begin
    int send_idx;
    int recv_idx;
    logic in_x;
    logic out_x;

    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    send_one("basic", 8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0);
    send_one("xnib", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    send_one("xnib_bin", 8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0);
    send_one("under", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    send_one("sovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    send_one("sovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    send_one("full_bin", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);

    // Backpressure: four back-to-back inputs, consumer stalled for 4 cycles.
    send_idx = 0;
    recv_idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (send_idx < 4);
      if (send_idx < 4) begin
        a = bp_a[send_idx]; b = bp_b[send_idx]; bin = 1'b0;
      end
      #1;
      if (cyc == 2) check("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
      if (out_valid) begin
        if (recv_idx < 4) begin
          check("bp_diff", {24'd0, diff}, {24'd0, bp_exp[recv_idx]});
          check("bp_bout", {31'd0, bout}, 32'd0);
        end else begin
          check("bp_extra_result", {31'd0, out_valid}, 32'd0);
        end
      end
      in_x  = in_valid & in_ready;
      out_x = out_valid & out_ready;
      step();
      if (in_x) send_idx++;
      if (out_x) recv_idx++;
    end
    in_valid = 1'b0;
    check("bp_recv_count", recv_idx, 32'd4);
    check("bp_send_count", send_idx, 32'd4);

    // Reset mid-flight with both stages full.
    out_ready = 1'b0;
    a = 8'h44; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h66; b = 8'h22;
    step();
    in_valid = 1'b0;
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    check("mid_pre_diff", {24'd0, diff}, 32'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_diff", {24'd0, diff}, 32'd0);
    check("mid_rst_bout", {31'd0, bout}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SUB_OVERFLOW_EN
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
